// File: rtl/acquisition_readout.sv
// acquisition_readout: drains a sample range from the acquisition DPRAM into a 32-bit
// AXI-stream, two left-aligned samples per word, wrapping circularly through the buffer.
module acquisition_readout #(
  parameter int ACQUISITION_BUFFER_CAPACITY = 65536,
  parameter int AXI_SAMPLES_PER_CLOCK       = 8,
  parameter int ADC_WIDTH                   = 14,
  parameter int READ_LATENCY                = 2,
  parameter int FIFO_DEPTH                  = 8,
  localparam int SIDX_W = $clog2(ACQUISITION_BUFFER_CAPACITY),
  localparam int ADDR_W = SIDX_W - $clog2(AXI_SAMPLES_PER_CLOCK),
  localparam int MUX_W  = $clog2(AXI_SAMPLES_PER_CLOCK + 1)
) (
  input  logic                 sysClk,
  input  logic                 sysReset_n,
  input  logic                 sysStart,
  input  logic [SIDX_W-1:0]    sysStartSample,
  input  logic [SIDX_W:0]      sysSampleCount,
  input  logic                 sysAbort,
  input  logic                 sysAcqFull,
  output logic                 sysBusy,
  output logic                 sysDone,
  output logic                 sysStartRejected,
  output logic [ADDR_W-1:0]    rdAddress,
  output logic [MUX_W-1:0]     rdMuxSelect,
  input  logic [ADC_WIDTH-1:0] rdData,
  output logic [31:0]          m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready
);
  localparam int LANE_W = $clog2(AXI_SAMPLES_PER_CLOCK);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int CNT_W  = SIDX_W + 1;
  localparam int CAP    = ACQUISITION_BUFFER_CAPACITY;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [SIDX_W-1:0]    idx;
  logic [CNT_W-1:0]     read_rem, out_rem;
  logic [READ_LATENCY:0] vld_p;
  logic [ADC_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     occ, reserved;
  logic                 start_ok, start_bad, abort_run, issue, wr, tlast_acc;
  logic                 last_odd, pair_ok, load;
  logic [1:0]           pop_n;
  logic [15:0]          lo_half, hi_half;

  function automatic logic [15:0] left_align(input logic [ADC_WIDTH-1:0] s);
    return 16'(s) << (16 - ADC_WIDTH);
  endfunction

  always_comb begin
    start_ok  = 1'b0;
    start_bad = 1'b0;
    if (state == IDLE && sysStart) begin
      if (sysAcqFull && ({1'b0, sysStartSample} < CNT_W'(CAP)) &&
          (sysSampleCount != '0) && (sysSampleCount <= CNT_W'(CAP)))
        start_ok = 1'b1;
      else
        start_bad = 1'b1;
    end
  end

  assign abort_run = sysAbort && (state != IDLE);
  assign wr        = vld_p[READ_LATENCY];
  assign tlast_acc = m_tvalid && m_tready && m_tlast;

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) state <= IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (abort_run) state_next = IDLE;
               else if (issue && read_rem == CNT_W'(1)) state_next = DRAIN;
      DRAIN:   if (abort_run || tlast_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Credit counts FIFO entries plus reads still in flight, so the FIFO cannot overflow.
  always_comb begin
    sysBusy = (state != IDLE);
    issue   = (state == RUN) && !sysAbort && (reserved < OCC_W'(FIFO_DEPTH));
  end

  always_comb begin
    last_odd = (out_rem == CNT_W'(1)) && (occ != '0);
    pair_ok  = (out_rem >= CNT_W'(2)) && (occ >= OCC_W'(2));
    load     = (!m_tvalid || m_tready) && (last_odd || pair_ok) && !abort_run;
    pop_n    = !load ? 2'd0 : (last_odd ? 2'd1 : 2'd2);
    lo_half  = left_align(fifo_mem[rd_ptr]);
    hi_half  = last_odd ? 16'h0 : left_align(fifo_mem[rd_ptr + PTR_W'(1)]);
  end

  always_ff @(posedge sysClk) begin
    if (wr) fifo_mem[wr_ptr] <= rdData;
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      sysDone          <= 1'b0;
      sysStartRejected <= 1'b0;
      rdAddress        <= '0;
      rdMuxSelect      <= '0;
      m_tdata          <= '0;
      m_tvalid         <= 1'b0;
      m_tlast          <= 1'b0;
      idx              <= '0;
      read_rem         <= '0;
      out_rem          <= '0;
      vld_p            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      reserved         <= '0;
    end else begin
      sysStartRejected <= start_bad;
      sysDone          <= tlast_acc && (state == DRAIN) && !abort_run;
      if (abort_run) begin
        vld_p    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        occ      <= '0;
        reserved <= '0;
        out_rem  <= '0;
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end else begin
        if (start_ok) begin
          idx      <= sysStartSample;
          read_rem <= sysSampleCount;
          out_rem  <= sysSampleCount;
        end
        // p0: read issue, address registered alongside its valid tag
        if (issue) begin
          rdAddress   <= idx[SIDX_W-1:LANE_W];
          rdMuxSelect <= MUX_W'(idx[LANE_W-1:0]);
          idx         <= (idx == SIDX_W'(CAP - 1)) ? '0 : idx + SIDX_W'(1);
          read_rem    <= read_rem - CNT_W'(1);
        end
        vld_p <= {vld_p[READ_LATENCY-1:0], issue};
        // pN: tag aligned with returning rdData, sample enters the FIFO
        if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
        occ      <= occ + OCC_W'(wr) - OCC_W'(pop_n);
        reserved <= reserved + OCC_W'(issue) - OCC_W'(pop_n);
        // output stage: pack one or two samples into the stream register
        if (load) begin
          m_tdata  <= {hi_half, lo_half};
          m_tvalid <= 1'b1;
          m_tlast  <= (out_rem <= CNT_W'(2));
          rd_ptr   <= rd_ptr + PTR_W'(pop_n);
          out_rem  <= out_rem - CNT_W'(pop_n);
        end else if (m_tready) begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_acquisition_readout.sv
// Bench for acquisition_readout: behavioural DPRAM plus a scoreboard of expected
// stream words, exercising wrap, odd counts, stalls, rejections, abort and reset.
`timescale 1ns/1ps
module tb_acquisition_readout;
  localparam int CAP = 64, APC = 4, ADW = 14, LAT = 2, DEPTH = 8;
  localparam int CAP2 = 48;

  logic clk = 1'b0, rst_n = 1'b1;
  logic sys_start = 1'b0, sys_abort = 1'b0, sys_acq = 1'b1, m_tready = 1'b1;
  logic [5:0] start_sample = '0;
  logic [6:0] sample_count = '0;
  logic sys_busy, sys_done, sys_rej, m_tvalid, m_tlast;
  logic [3:0] rd_address;
  logic [2:0] rd_mux;
  logic [ADW-1:0] rd_data = '0, rd_p1 = '0;
  logic [31:0] m_tdata;

  logic start2 = 1'b0, abort2 = 1'b0, one = 1'b1;
  logic [5:0] sample2 = '0;
  logic [6:0] count2 = '0;
  logic [ADW-1:0] zero_data = '0;
  logic busy2, done2, rej2, tvalid2, tlast2;
  logic [3:0] addr2;
  logic [2:0] mux2;
  logic [31:0] tdata2;

  int checks = 0, errors = 0, done_cnt = 0, rej_cnt = 0, rej2_cnt = 0;
  logic [32:0] exp_q[$], obs_q[$];

  acquisition_readout #(.ACQUISITION_BUFFER_CAPACITY(CAP), .AXI_SAMPLES_PER_CLOCK(APC),
    .ADC_WIDTH(ADW), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .sysClk(clk), .sysReset_n(rst_n), .sysStart(sys_start), .sysStartSample(start_sample),
    .sysSampleCount(sample_count), .sysAbort(sys_abort), .sysAcqFull(sys_acq),
    .sysBusy(sys_busy), .sysDone(sys_done), .sysStartRejected(sys_rej),
    .rdAddress(rd_address), .rdMuxSelect(rd_mux), .rdData(rd_data),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready));

  acquisition_readout #(.ACQUISITION_BUFFER_CAPACITY(CAP2), .AXI_SAMPLES_PER_CLOCK(APC),
    .ADC_WIDTH(ADW), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut2 (
    .sysClk(clk), .sysReset_n(rst_n), .sysStart(start2), .sysStartSample(sample2),
    .sysSampleCount(count2), .sysAbort(abort2), .sysAcqFull(one),
    .sysBusy(busy2), .sysDone(done2), .sysStartRejected(rej2),
    .rdAddress(addr2), .rdMuxSelect(mux2), .rdData(zero_data),
    .m_tdata(tdata2), .m_tvalid(tvalid2), .m_tlast(tlast2), .m_tready(one));

  always #5 clk = ~clk;

  function automatic logic [ADW-1:0] f(input int i);
    return ADW'(32'h2000 + i * 97 + 3);
  endfunction

  // DPRAM model with two clocks of read latency
  always @(posedge clk) begin
    rd_p1   <= f(int'(rd_address) * APC + int'(rd_mux));
    rd_data <= rd_p1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
      if (sys_done) done_cnt++;
      if (sys_rej) rej_cnt++;
      if (rej2) rej2_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int s, input int c);
    for (int k = 0; k < c; k += 2) begin
      logic [15:0] lo, hi;
      lo = {f((s + k) % CAP), 2'b00};
      hi = (k + 1 < c) ? {f((s + k + 1) % CAP), 2'b00} : 16'h0;
      exp_q.push_back({(k + 2 >= c), hi, lo});
    end
  endtask

  task automatic start(input int s, input int c);
    sys_start = 1'b1;
    start_sample = 6'(s);
    sample_count = 7'(c);
    tick();
    sys_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    int n = 0;
    while (sys_busy && n < max_cyc) begin
      tick();
      n++;
    end
    timed_out = sys_busy;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_busy, sys_done, sys_rej, m_tvalid, m_tlast} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: busy/done/rej/tvalid/tlast=%b, want 00000",
        {sys_busy, sys_done, sys_rej, m_tvalid, m_tlast});
    end
    checks++;
    if ({rd_address, rd_mux} !== 7'b0 || m_tdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr=%0d mux=%0d tdata=%h, want 0", rd_address, rd_mux, m_tdata);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (sys_busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b, want 0", sys_busy); end
  endtask

  task automatic test_straight();
    int d0, first_v;
    bit to;
    logic [32:0] e, o;
    d0 = done_cnt;
    first_v = -1;
    push_exp(10, 8);
    start(10, 8);
    checks++;
    if (sys_busy !== 1'b1) begin errors++; $display("FAIL straight_busy: busy=%b, want 1", sys_busy); end
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({rd_address, rd_mux} !== {4'((10 + c - 1) / APC), 3'((10 + c - 1) % APC)}) begin
        errors++; $display("FAIL straight_addr: cycle %0d addr=%0d mux=%0d, want %0d,%0d",
          c, rd_address, rd_mux, (10 + c - 1) / APC, (10 + c - 1) % APC);
      end
      if (m_tvalid && first_v < 0) first_v = c;
    end
    checks++;
    if (first_v != LAT + 4) begin errors++; $display("FAIL straight_latency: first tvalid cycle %0d, want %0d", first_v, LAT + 4); end
    wait_idle(200, to);
    checks++;
    if (to || obs_q.size() != 4) begin errors++; $display("FAIL straight_count: words=%0d timeout=%0d, want 4 words", obs_q.size(), to); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL straight_word: got %h, want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL straight_done: pulses=%0d, want 1", done_cnt - d0); end
  endtask

  task automatic test_patterns();
    int tbl [3][2] = '{'{62, 4}, '{5, 3}, '{0, 1}};
    int d0, nexp;
    bit to;
    logic [32:0] e, o;
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      push_exp(tbl[i][0], tbl[i][1]);
      nexp = exp_q.size();
      start(tbl[i][0], tbl[i][1]);
      wait_idle(200, to);
      checks++;
      if (to || obs_q.size() != nexp) begin
        errors++; $display("FAIL pattern_count: start %0d words=%0d, want %0d", tbl[i][0], obs_q.size(), nexp);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL pattern_word: start %0d got %h, want %h", tbl[i][0], o, e); end
      end
      exp_q.delete(); obs_q.delete();
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL pattern_done: pulses=%0d, want 1", done_cnt - d0); end
    end
  endtask

  task automatic test_reject();
    int tbl [3][3] = '{'{0, 10, 8}, '{1, 10, 0}, '{1, 10, 65}};
    int r0;
    for (int i = 0; i < 3; i++) begin
      r0 = rej_cnt;
      sys_acq = (tbl[i][0] != 0);
      start(tbl[i][1], tbl[i][2]);
      repeat (8) tick();
      checks++;
      if (rej_cnt != r0 + 1 || sys_busy !== 1'b0 || obs_q.size() != 0) begin
        errors++; $display("FAIL reject_case%0d: pulses=%0d busy=%b words=%0d, want 1,0,0",
          i, rej_cnt - r0, sys_busy, obs_q.size());
      end
      sys_acq = 1'b1;
    end
    r0 = rej2_cnt;
    start2 = 1'b1; sample2 = 6'(CAP2); count2 = 7'd4;
    tick(); start2 = 1'b0;
    repeat (3) tick();
    checks++;
    if (rej2_cnt != r0 + 1 || busy2 !== 1'b0) begin
      errors++; $display("FAIL reject_start_range: pulses=%0d busy=%b, want 1,0", rej2_cnt - r0, busy2);
    end
    start2 = 1'b1; sample2 = 6'(CAP2 - 1); count2 = 7'(CAP2);
    tick(); start2 = 1'b0;
    repeat (3) tick();
    checks++;
    if (rej2_cnt != r0 + 1 || busy2 !== 1'b1) begin
      errors++; $display("FAIL accept_edge: pulses=%0d busy=%b, want 1,1", rej2_cnt - r0, busy2);
    end
    abort2 = 1'b1; tick(); abort2 = 1'b0;
    checks++;
    if (busy2 !== 1'b0 || tvalid2 !== 1'b0) begin
      errors++; $display("FAIL abort2: busy=%b tvalid=%b, want 0,0", busy2, tvalid2);
    end
  endtask

  task automatic test_busy_start();
    int d0, r0;
    bit to;
    logic [32:0] e, o;
    d0 = done_cnt; r0 = rej_cnt;
    push_exp(0, 12);
    start(0, 12);
    repeat (3) tick();
    sys_acq = 1'b0;
    start(30, 4);
    wait_idle(300, to);
    sys_acq = 1'b1;
    checks++;
    if (to || rej_cnt != r0 || obs_q.size() != 6) begin
      errors++; $display("FAIL busy_start: rej=%0d words=%0d timeout=%0d, want 0,6,0", rej_cnt - r0, obs_q.size(), to);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL busy_word: got %h, want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done: pulses=%0d, want 1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    bit stall = 1'b0;
    logic [32:0] hold, e, o;
    logic [6:0] rd_hold;
    push_exp(20, 64);
    start(20, 64);
    while (sys_busy && cyc < 3000) begin
      tick();
      cyc++;
      if (stall) begin
        checks++;
        if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== hold) begin
          errors++; $display("FAIL stall_hold: cycle %0d tvalid=%b word=%h, want 1 %h", cyc, m_tvalid, {m_tlast, m_tdata}, hold);
        end
      end
      if (cyc == 45) rd_hold = {rd_address, rd_mux};
      if (cyc == 49) begin
        checks++;
        if ({rd_address, rd_mux} !== rd_hold) begin
          errors++; $display("FAIL stall_reads: read position %h, want held at %h", {rd_address, rd_mux}, rd_hold);
        end
      end
      m_tready = (cyc >= 30 && cyc < 50) ? 1'b0 : 1'($urandom_range(0, 1));
      stall = m_tvalid && !m_tready;
      hold = {m_tlast, m_tdata};
    end
    m_tready = 1'b1;
    repeat (3) tick();
    checks++;
    if (sys_busy || obs_q.size() != 32) begin
      errors++; $display("FAIL bp_count: words=%0d busy=%b, want 32,0", obs_q.size(), sys_busy);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL bp_word: got %h, want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_abort();
    int d0, n;
    bit to;
    logic [32:0] e, o;
    d0 = done_cnt;
    push_exp(40, 16);
    start(40, 16);
    n = 0;
    while (obs_q.size() < 3 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (obs_q.size() < 3) begin errors++; $display("FAIL abort_wait: words=%0d, want 3", obs_q.size()); end
    sys_abort = 1'b1;
    tick();
    sys_abort = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0 || sys_busy !== 1'b0) begin
      errors++; $display("FAIL abort_drop: tvalid=%b busy=%b, want 0,0", m_tvalid, sys_busy);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL abort_prefix: got %h, want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    push_exp(3, 6);
    start(3, 6);
    wait_idle(200, to);
    checks++;
    if (to || obs_q.size() != 3) begin errors++; $display("FAIL restart_count: words=%0d, want 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL restart_word: got %h, want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_done: pulses=%0d, want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    start(0, 32);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_busy, sys_done, sys_rej, m_tvalid, m_tlast} !== 5'b0 || {rd_address, rd_mux} !== 7'b0 || m_tdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid: busy=%b tvalid=%b addr=%0d mux=%0d tdata=%h, want all 0",
        sys_busy, m_tvalid, rd_address, rd_mux, m_tdata);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_straight();
    test_patterns();
    test_reject();
    test_busy_start();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
